// File: rtl/osc_ctrl_pkg.sv
// Shared types and defaults for the HF oscillator runtime sequencer.
// No logic; imported by the controller and its timer.
package osc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATE   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_FINISH = 2'd3
   } osc_state_e;

   localparam int         DIV_W_DEF     = 8;
   localparam logic [7:0] RESET_DIV_DEF = 8'd1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/osc_ctrl_timer.sv
// Loadable down-counter with zero flag; shared by the gate and settle waits.
// Load wins over decrement; the count saturates at zero and never wraps.
module osc_ctrl_timer
   import osc_ctrl_pkg::*;
#(
   parameter int CW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/osc_hf_ctrl.sv
// Glitch-safe runtime sequencer for the OSC_CORE HF divider/enable controls.
// Gate output, wait, change divider, wait for settle, re-enable; one request at a time.
module osc_hf_ctrl
   import osc_ctrl_pkg::*;
#(
   parameter int               DIV_W         = DIV_W_DEF,
   parameter logic [DIV_W-1:0] RESET_DIV     = DIV_W'(RESET_DIV_DEF),
   parameter int               GATE_CYCLES   = 4,
   parameter int               SETTLE_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DIV_W-1:0] req_div,
   input  logic             req_en,
   output logic             done,
   output logic             busy,
   output logic             osc_hfouten,
   output logic [DIV_W-1:0] osc_hf_div,
   output logic             cur_en
);

   localparam int CW = $clog2(max_int(GATE_CYCLES, SETTLE_CYCLES) + 1);
   localparam logic [CW-1:0] GATE_LOAD   = CW'(GATE_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

   osc_state_e       state_q;
   logic             hfouten_q;
   logic [DIV_W-1:0] div_q;
   logic             cur_en_q;
   logic             done_q;
   logic [DIV_W-1:0] lat_div_q;
   logic             lat_en_q;

   logic             accept;
   logic             is_noop;
   logic             tmr_load_d;
   logic [CW-1:0]    tmr_val_d;
   logic             tmr_dec_d;
   logic             tmr_zero;

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign is_noop   = (req_div == div_q) && (req_en == cur_en_q);

   // The same timer covers both waits: loaded on entry to GATE, reloaded on GATE->SETTLE.
   always_comb begin
      tmr_load_d = 1'b0;
      tmr_val_d  = GATE_LOAD;
      tmr_dec_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmr_load_d = accept && !is_noop;
         end
         ST_GATE: begin
            tmr_load_d = tmr_zero && lat_en_q;
            tmr_val_d  = SETTLE_LOAD;
            tmr_dec_d  = !tmr_zero;
         end
         ST_SETTLE: begin
            tmr_dec_d  = !tmr_zero;
         end
         default: begin
            tmr_load_d = 1'b0;
         end
      endcase
   end

   osc_ctrl_timer #(
      .CW (CW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load_d),
      .load_val_i (tmr_val_d),
      .dec_i      (tmr_dec_d),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         hfouten_q <= 1'b0;
         div_q     <= RESET_DIV;
         cur_en_q  <= 1'b0;
         done_q    <= 1'b0;
         lat_div_q <= '0;
         lat_en_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  lat_div_q <= req_div;
                  lat_en_q  <= req_en;
                  if (is_noop) begin
                     state_q <= ST_FINISH;
                  end else begin
                     hfouten_q <= 1'b0;
                     state_q   <= ST_GATE;
                  end
               end
            end
            ST_GATE: begin
               if (tmr_zero) begin
                  div_q   <= lat_div_q;
                  state_q <= lat_en_q ? ST_SETTLE : ST_FINISH;
               end
            end
            ST_SETTLE: begin
               if (tmr_zero) begin
                  hfouten_q <= 1'b1;
                  state_q   <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               done_q   <= 1'b1;
               cur_en_q <= lat_en_q;
               state_q  <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign osc_hfouten = hfouten_q;
   assign osc_hf_div  = div_q;
   assign cur_en      = cur_en_q;
   assign done        = done_q;

endmodule
